// File: rtl/drp_pkg.sv
// Shared definitions for the DRP write/verify engine: bus widths, FSM state
// encoding and response status codes.
package drp_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK       = 2'b00,
    RSP_MISMATCH = 2'b01,
    RSP_TIMEOUT  = 2'b10
  } rsp_status_e;

  // A one-cycle timeout still needs a one-bit counter.
  function automatic int ctr_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/drp_writer_if.sv
// Command/response handshake plus the DRP port bundle of drp_writer.
interface drp_writer_if;
  import drp_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic [ADDR_W-1:0] daddr_out;
  logic              den_out;
  logic              dwe_out;
  logic [DATA_W-1:0] di_out;
  logic [DATA_W-1:0] do_in;
  logic              drdy_in;

  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, do_in, drdy_in,
    output cmd_ready, daddr_out, den_out, dwe_out, di_out,
           rsp_valid, rsp_status, rsp_rdata, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, do_in, drdy_in,
    input  cmd_ready, daddr_out, den_out, dwe_out, di_out,
           rsp_valid, rsp_status, rsp_rdata, busy
  );

endinterface

// File: rtl/drp_timeout_ctr.sv
// Wait-cycle counter: held at zero while cleared, counts while enabled and
// flags the last permitted wait cycle.
module drp_timeout_ctr
  import drp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int         W    = ctr_width(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/drp_writer.sv
// DRP write engine: issues one write strobe, optionally reads the register
// back, and reports OK / MISMATCH / TIMEOUT with a one-cycle response pulse.
module drp_writer
  import drp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int VERIFY      = 1
) (
  input logic         clk,
  input logic         rst_n,
  drp_writer_if.slave bus
);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  rsp_status_e       status_q, status_d;

  logic in_wait;
  logic wait_clear;
  logic expired;

  assign in_wait    = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);
  assign wait_clear = !in_wait;

  drp_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clear),
    .enable (in_wait),
    .expired(expired)
  );

  // Outputs are computed from the next state so they are registered and line
  // up with the state they belong to; den/dwe/rsp_valid are single-cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    rsp_valid_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = ST_WR_ISSUE;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_data;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        // drdy takes priority over a timeout expiring on the same cycle.
        if (bus.drdy_in) begin
          if (VERIFY != 0) begin
            state_d = ST_RD_ISSUE;
            den_d   = 1'b1;
          end else begin
            state_d     = ST_RESP;
            status_d    = RSP_OK;
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
          end
        end else if (expired) begin
          state_d     = ST_RESP;
          status_d    = RSP_TIMEOUT;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (bus.drdy_in) begin
          state_d     = ST_RESP;
          rdata_d     = bus.do_in;
          status_d    = (bus.do_in == wdata_q) ? RSP_OK : RSP_MISMATCH;
          rsp_valid_d = 1'b1;
        end else if (expired) begin
          state_d     = ST_RESP;
          status_d    = RSP_TIMEOUT;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= RSP_OK;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.den_out    = den_q;
  assign bus.dwe_out    = dwe_q;
  assign bus.daddr_out  = addr_q;
  assign bus.di_out     = wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = status_q;
  assign bus.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_drp_writer.sv
// Bench for drp_writer: a VERIFY=1 and a VERIFY=0 instance share stimulus,
// a DRP responder answers each den after a chosen delay, results vs model.
module tb_drp_writer;
  import drp_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drp_writer_if if_v ();
  drp_writer_if if_n ();

  drp_writer #(.TIMEOUT_CYC(TO), .VERIFY(1)) dut_v (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_v.slave)
  );

  drp_writer #(.TIMEOUT_CYC(TO), .VERIFY(0)) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_n.slave)
  );

  bit          sel;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] do_in;
  logic        drdy;

  assign if_v.cmd_valid = sel & cmd_valid;
  assign if_v.cmd_addr  = cmd_addr;
  assign if_v.cmd_data  = cmd_data;
  assign if_v.do_in     = do_in;
  assign if_v.drdy_in   = sel & drdy;
  assign if_n.cmd_valid = !sel & cmd_valid;
  assign if_n.cmd_addr  = cmd_addr;
  assign if_n.cmd_data  = cmd_data;
  assign if_n.do_in     = do_in;
  assign if_n.drdy_in   = !sel & drdy;

  int n_checks = 0;
  int n_err    = 0;

  // Sampled view of the selected instance.
  logic        s_ready, s_den, s_dwe, s_rsp, s_busy;
  logic [6:0]  s_daddr;
  logic [15:0] s_di, s_rdata;
  logic [1:0]  s_status;

  // Responder and monitor state.
  int          cyc, ack_at, wr_delay, rd_delay;
  logic [15:0] rd_value, last_wr;
  bit          mirror, waiting;
  int          n_den_wr, n_den_rd, n_rsp, n_acc;
  int          acc_first, acc_last, rsp_first, rsp_last, den_first, den_last, viol;
  logic [6:0]  lat_addr;
  logic [15:0] lat_data;
  logic [1:0]  got_status;
  logic [15:0] got_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (sel) begin
      s_ready = if_v.cmd_ready; s_den = if_v.den_out; s_dwe = if_v.dwe_out;
      s_rsp = if_v.rsp_valid; s_busy = if_v.busy; s_daddr = if_v.daddr_out;
      s_di = if_v.di_out; s_rdata = if_v.rsp_rdata; s_status = if_v.rsp_status;
    end else begin
      s_ready = if_n.cmd_ready; s_den = if_n.den_out; s_dwe = if_n.dwe_out;
      s_rsp = if_n.rsp_valid; s_busy = if_n.busy; s_daddr = if_n.daddr_out;
      s_di = if_n.di_out; s_rdata = if_n.rsp_rdata; s_status = if_n.rsp_status;
    end
  endtask

  task automatic clear_mon();
    n_den_wr = 0; n_den_rd = 0; n_rsp = 0; n_acc = 0;
    acc_first = -1; acc_last = -1; rsp_first = -1; rsp_last = -1;
    den_first = -1; den_last = -10; viol = 0;
    ack_at = -1; waiting = 0; drdy = 1'b0;
  endtask

  // One clock: record acceptance, then observe the cycle after the edge and
  // drive drdy/do_in for the edge that closes it.
  task automatic step();
    int d;
    sample();
    if (cmd_valid && s_ready) begin
      n_acc++;
      if (acc_first < 0) acc_first = cyc;
      acc_last = cyc;
      lat_addr = cmd_addr;
      lat_data = cmd_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    sample();
    if (s_den) begin
      if (den_last == cyc - 1 || waiting) viol++;
      if (s_daddr !== lat_addr) viol++;
      if (s_dwe) begin
        n_den_wr++;
        last_wr = s_di;
        if (s_di !== lat_data) viol++;
        d = wr_delay;
      end else begin
        n_den_rd++;
        d = rd_delay;
      end
      if (den_first < 0) den_first = cyc;
      den_last = cyc;
      waiting  = 1;
      ack_at   = (d >= 0) ? cyc + d : -1;
    end else if (s_dwe) begin
      viol++;
    end
    if (s_busy == s_ready) viol++;
    if (s_rsp) begin
      n_rsp++;
      if (rsp_first < 0) rsp_first = cyc;
      rsp_last   = cyc;
      got_status = s_status;
      got_rdata  = s_rdata;
      waiting    = 0;
    end
    drdy = (ack_at >= 0) && (cyc == ack_at);
    if (drdy) waiting = 0;
    do_in = mirror ? last_wr : rd_value;
  endtask

  // Expected outcome from the delay rules: an answer counts if it arrives
  // 1..TO cycles after its den; latency is measured from the write den.
  function automatic void model(input bit verify, input int wd, input int rd,
                                input logic [15:0] wdata, input logic [15:0] rv,
                                output logic [1:0] st, output logic [15:0] rdat,
                                output int n_rd, output int lat, output bit chk);
    bit wr_ack = (wd >= 1) && (wd <= TO);
    bit rd_ack = (rd >= 1) && (rd <= TO);
    rdat = '0; chk = 0; n_rd = 0;
    if (!wr_ack) begin
      st = 2'b10; lat = TO + 1;
    end else if (!verify) begin
      st = 2'b00; lat = wd + 1; chk = 1;
    end else begin
      n_rd = 1;
      if (rd_ack) begin
        st = (rv == wdata) ? 2'b00 : 2'b01; rdat = rv; lat = wd + rd + 2; chk = 1;
      end else begin
        st = 2'b10; lat = wd + TO + 2;
      end
    end
  endfunction

  task automatic run_cmd(input string tag, input bit s, input logic [6:0] a,
                         input logic [15:0] dat, input int wd, input int rd,
                         input logic [15:0] rv);
    logic [1:0]  e_st;
    logic [15:0] e_rd;
    int          e_nrd, e_lat;
    bit          e_chk;
    bit          done = 0;
    sel = s; mirror = 0; wr_delay = wd; rd_delay = rd; rd_value = rv;
    clear_mon();
    cmd_addr = a; cmd_data = dat; cmd_valid = 1'b1;
    for (int i = 0; i < 4 * TO + 40 && !done; i++) begin
      step();
      if (n_acc > 0) cmd_valid = 1'b0;
      if (n_rsp > 0 && cyc >= rsp_last + 3) done = 1;
    end
    cmd_valid = 1'b0;
    model(s, wd, rd, dat, rv, e_st, e_rd, e_nrd, e_lat, e_chk);
    check({tag, "/finished"}, 32'(done), 1);
    check({tag, "/accepts"}, n_acc, 1);
    check({tag, "/den_latency"}, den_first - acc_first, 1);
    check({tag, "/wr_dens"}, n_den_wr, 1);
    check({tag, "/rd_dens"}, n_den_rd, e_nrd);
    check({tag, "/rsp_pulses"}, n_rsp, 1);
    check({tag, "/rsp_latency"}, rsp_first - den_first, e_lat);
    check({tag, "/status"}, got_status, e_st);
    if (e_chk) check({tag, "/rdata"}, got_rdata, e_rd);
    check({tag, "/protocol"}, viol, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/v_ctl"}, {if_v.cmd_ready, if_v.den_out, if_v.dwe_out, if_v.rsp_valid, if_v.busy}, 5'b10000);
    check({tag, "/v_bus"}, {if_v.daddr_out, if_v.di_out}, 0);
    check({tag, "/v_rsp"}, {if_v.rsp_status, if_v.rsp_rdata}, 0);
    check({tag, "/n_ctl"}, {if_n.cmd_ready, if_n.den_out, if_n.dwe_out, if_n.rsp_valid, if_n.busy}, 5'b10000);
    check({tag, "/n_bus"}, {if_n.daddr_out, if_n.di_out}, 0);
    check({tag, "/n_rsp"}, {if_n.rsp_status, if_n.rsp_rdata}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ra;
    logic [15:0] rdat, rrv;
    int          rwd, rrd;
    bit          rs, switched, done;

    sel = 1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; do_in = '0;
    mirror = 0; rd_value = '0; last_wr = '0; wr_delay = -1; rd_delay = -1;
    lat_addr = '0; lat_data = '0; got_status = '0; got_rdata = '0; cyc = 0;
    clear_mon();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk) rst_n = 1'b1;

    // Directed cases.
    run_cmd("wr_rd_ok", 1, 7'h41, 16'h2F00, 3, 3, 16'h2F00);
    run_cmd("rd_differs", 1, 7'h41, 16'h2F00, 3, 3, 16'h2E00);
    run_cmd("wr_timeout", 1, 7'h12, 16'h1234, -1, 3, 16'h0000);
    run_cmd("nv_edge_ack", 0, 7'h33, 16'hBEEF, TO, -1, 16'h5555);
    run_cmd("v_edge_ack", 1, 7'h05, 16'hA5A5, TO, TO, 16'hA5A5);
    run_cmd("rd_timeout", 1, 7'h06, 16'h0F0F, 1, -1, 16'h0000);
    run_cmd("wr_late_ack", 1, 7'h07, 16'h0707, TO + 1, 2, 16'h0707);
    run_cmd("nv_quick", 0, 7'h7F, 16'hFFFF, 1, -1, 16'h1234);

    // Randomized cases.
    for (int k = 0; k < 12; k++) begin
      rs   = 1'($urandom_range(0, 1));
      ra   = 7'($urandom);
      rdat = 16'($urandom);
      rwd  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 2));
      rrd  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 2));
      rrv  = ($urandom_range(0, 1) == 1) ? rdat : 16'($urandom);
      run_cmd($sformatf("rand%0d", k), rs, ra, rdat, rwd, rrd, rrv);
    end

    // Reset while waiting for the read-back, followed by a stray drdy.
    sel = 1; mirror = 0; wr_delay = 2; rd_delay = -1; rd_value = '0;
    clear_mon();
    cmd_addr = 7'h2A; cmd_data = 16'h7777; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && n_den_rd == 0; i++) begin
      step();
      if (n_acc > 0) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("mid_rst/reached_read", n_den_rd, 1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    ack_at = cyc + 1;
    repeat (5) step();
    check("mid_rst/no_rsp", n_rsp, 0);
    check("mid_rst/no_den", n_den_wr + n_den_rd, 0);
    check("mid_rst/idle", {s_busy, s_ready, s_status}, 4'b0100);
    check("mid_rst/rdata", s_rdata, 0);
    run_cmd("after_rst", 1, 7'h2A, 16'h7777, 2, 2, 16'h7777);

    // Back-to-back commands with cmd_valid held high.
    sel = 1; mirror = 1; wr_delay = 2; rd_delay = 3;
    clear_mon();
    cmd_addr = 7'h10; cmd_data = 16'h1111; cmd_valid = 1'b1;
    switched = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (n_acc == 1 && !switched) begin
        cmd_addr = 7'h11; cmd_data = 16'h2222; switched = 1;
      end
      if (n_acc >= 2) cmd_valid = 1'b0;
      if (n_rsp >= 2 && cyc >= rsp_last + 3) done = 1;
    end
    cmd_valid = 1'b0;
    mirror = 0;
    check("b2b/finished", 32'(done), 1);
    check("b2b/accepts", n_acc, 2);
    check("b2b/second_accept", acc_last - rsp_first, 1);
    check("b2b/wr_dens", n_den_wr, 2);
    check("b2b/rd_dens", n_den_rd, 2);
    check("b2b/rsp_pulses", n_rsp, 2);
    check("b2b/status", got_status, 2'b00);
    check("b2b/rdata", got_rdata, 16'h2222);
    check("b2b/protocol", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/drp_writer.md
DRP_WRITER -- requirements
Module: drp_writer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles to wait for drdy after a den strobe.
REQ-002 SHALL have parameter VERIFY, default 1: when 1, every write is followed by a read-back of the same address.
REQ-003 SHALL have port clk, input, 1: the single clock, shared with the DRP (dclk).
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: write command offered.
REQ-006 SHALL have port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-007 SHALL have port cmd_addr, input, 7: DRP register address.
REQ-008 SHALL have port cmd_data, input, 16: data to write.
REQ-009 SHALL have port daddr_out, output, 7: DRP address.
REQ-010 SHALL have port den_out, output, 1: DRP enable strobe.
REQ-011 SHALL have port dwe_out, output, 1: DRP write enable.
REQ-012 SHALL have port di_out, output, 16: DRP write data.
REQ-013 SHALL have port do_in, input, 16: DRP read data.
REQ-014 SHALL have port drdy_in, input, 1: DRP ready.
REQ-015 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port rsp_status, output, 2: 00 OK, 01 MISMATCH, 10 TIMEOUT.
REQ-017 SHALL have port rsp_rdata, output, 16: read-back value (0 when VERIFY=0).
REQ-018 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready, and cmd_addr/cmd_data are latched on that edge.
REQ-021 IDLE SHALL go to WR_ISSUE on acceptance; in WR_ISSUE, den_out=1 and dwe_out=1 for exactly one cycle, with daddr_out/di_out carrying the latched values; the next state is WR_WAIT.
REQ-022 den_out SHALL be asserted the cycle after acceptance (latency 1).
REQ-023 WR_WAIT SHALL go, on drdy_in, to RD_ISSUE when VERIFY=1, else to RESP with status OK.
REQ-024 RD_ISSUE SHALL assert den_out=1, dwe_out=0 for one cycle at the same address, then go to RD_WAIT.
REQ-025 RD_WAIT SHALL capture do_in into rsp_rdata on drdy_in, setting status OK if it equals the latched data, else MISMATCH; the next state is RESP.
REQ-026 In either WAIT state, the wait counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYC-1 without drdy_in, the FSM goes to RESP with TIMEOUT.
REQ-027 When drdy_in and timeout expiry coincide, drdy_in SHALL win.
REQ-028 RESP SHALL assert rsp_valid for one cycle and return to IDLE; rsp_status/rsp_rdata SHALL hold until the next RESP.
REQ-029 drdy_in outside the WAIT states SHALL be ignored with no state change.
REQ-030 den_out SHALL never be high on two consecutive cycles, and never be high while a previous den_out is awaiting drdy_in.
REQ-031 dwe_out SHALL be 0 whenever den_out is 0; daddr_out/di_out SHALL hold the latched values while busy.

Reset
REQ-032 On rst_n low, the block SHALL asynchronously enter IDLE with cmd_ready=1 and den_out, dwe_out, rsp_valid, busy = 0; daddr_out, di_out, rsp_rdata = 0; rsp_status = 00; and counter = 0.
REQ-033 Reset mid-transaction SHALL abort the transaction with no rsp_valid pulse; drdy_in arriving after release SHALL be ignored per REQ-029.

Structure
REQ-034 Package drp_pkg SHALL hold the FSM state encoding, the rsp_status codes (OK/MISMATCH/TIMEOUT), and DRP address/data width constants (7/16).
REQ-035 The wait counter SHALL be the sub-module drp_timeout_ctr (inputs clear/enable, output expired), sized $clog2(TIMEOUT_CYC).

Verification
REQ-036 Write 0x41 <= 0x2F00 with the DRP model answering drdy 3 cycles after den and returning 0x2F00 -> one den with dwe, one den without, rsp_valid once, status 00, rsp_rdata 0x2F00.
REQ-037 Model returns 0x2E00 on read-back -> status 01, rsp_rdata 0x2E00.
REQ-038 Model never asserts drdy -> rsp_valid exactly TIMEOUT_CYC cycles after den entry in WR_WAIT, status 10, no read issued.
REQ-039 drdy asserted on the timeout cycle -> treated as ack, status 00; with VERIFY=0, exactly one den, rsp_rdata 0.
REQ-040 rst_n pulsed low during RD_WAIT, then a late drdy -> outputs at reset values, no rsp_valid, next command completes normally.
REQ-041 Back-to-back commands with cmd_valid held high -> cmd_ready low while busy, second command accepted the cycle after RESP, den_out never on consecutive cycles.
